// File: rtl/maze_rom_arbiter.sv
// Two-port round-robin arbiter in front of the maze ROM's single read port.
// One ROM access is in flight at a time: IDLE -> ISSUE -> WAIT (ROM_LAT cycles) -> RESP.
module maze_rom_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 16,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req0,
  input  logic [AW-1:0] i_addr0,
  output logic          o_ack0,
  output logic [DW-1:0] o_data0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_addr1,
  output logic          o_ack1,
  output logic [DW-1:0] o_data1,
  output logic          o_rom_en,
  output logic [AW-1:0] o_rom_addr,
  input  logic [DW-1:0] i_rom_data,
  output logic          o_busy,
  output logic [7:0]    o_contend
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(ROM_LAT - 1);

  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic [7:0]    contend_q, contend_d;
  logic          rom_en_q, rom_en_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;

  logic          both;
  logic          grant;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign both  = i_req0 & i_req1;
  // A tie goes to the port that did not win last time.
  assign grant = both ? ~last_q : i_req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      cnt_q     <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      contend_q <= '0;
      rom_en_q  <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      contend_q <= contend_d;
      rom_en_q  <= rom_en_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; every output is the registered copy of its _d value.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_d    = last_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    contend_d = contend_q;
    rom_en_d  = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_req0 | i_req1) begin
          win_d    = grant;
          last_d   = grant;
          addr_d   = grant ? i_addr1 : i_addr0;
          rom_en_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ISSUE;
          if (both) begin
            contend_d = sat_inc(contend_q);
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (win_q) begin
            data1_d = i_rom_data;
            ack1_d  = 1'b1;
          end else begin
            data0_d = i_rom_data;
            ack0_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_rom_en   = rom_en_q;
  assign o_rom_addr = addr_q;
  assign o_ack0     = ack0_q;
  assign o_ack1     = ack1_q;
  assign o_data0    = data0_q;
  assign o_data1    = data1_q;
  assign o_busy     = busy_q;
  assign o_contend  = contend_q;

endmodule

// File: tb/tb_maze_rom_arbiter.sv
// Bench for maze_rom_arbiter: ROM_LAT=1 instance tracked by a timeline model every cycle,
// plus a ROM_LAT=3 instance checked with literal expectations.
module tb_maze_rom_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int LA = 1;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req0_a, req1_a, ack0_a, ack1_a, rom_en_a, busy_a;
  logic [AW-1:0] addr0_a, addr1_a, rom_addr_a;
  logic [DW-1:0] data0_a, data1_a, rom_data_a;
  logic [7:0]    contend_a;

  logic          req0_b, req1_b, ack0_b, ack1_b, rom_en_b, busy_b;
  logic [AW-1:0] addr0_b, addr1_b, rom_addr_b;
  logic [DW-1:0] data0_b, data1_b, rom_data_b;
  logic [7:0]    contend_b;

  int total = 0;
  int bad = 0;

  maze_rom_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(LA)) dut_a (
    .clk(clk), .rst(rst_n),
    .i_req0(req0_a), .i_addr0(addr0_a), .o_ack0(ack0_a), .o_data0(data0_a),
    .i_req1(req1_a), .i_addr1(addr1_a), .o_ack1(ack1_a), .o_data1(data1_a),
    .o_rom_en(rom_en_a), .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a),
    .o_busy(busy_a), .o_contend(contend_a)
  );

  maze_rom_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(LB)) dut_b (
    .clk(clk), .rst(rst_n),
    .i_req0(req0_b), .i_addr0(addr0_b), .o_ack0(ack0_b), .o_data0(data0_b),
    .i_req1(req1_b), .i_addr1(addr1_b), .o_ack1(ack1_b), .o_data1(data1_b),
    .o_rom_en(rom_en_b), .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
    .o_busy(busy_b), .o_contend(contend_b)
  );

  function automatic logic [15:0] romf(input logic [10:0] a);
    return {5'b0, a};
  endfunction

  // ROM models: data valid ROM_LAT cycles after the enable cycle, junk otherwise.
  logic [15:0] pa;
  logic [15:0] pb [0:2];
  always @(posedge clk) begin
    pa    <= rom_en_a ? romf(rom_addr_a) : 16'hDEAD;
    pb[0] <= rom_en_b ? romf(rom_addr_b) : 16'hDEAD;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign rom_data_a = pa;
  assign rom_data_b = pb[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model of instance A: mt = cycles since the granting IDLE cycle, -1 when idle.
  int          mt;
  logic        mwin, mlast;
  logic [10:0] maddr;
  logic [15:0] md0, md1;
  int          mcont;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt = -1; mwin = 1'b0; mlast = 1'b1; maddr = '0; md0 = '0; md1 = '0; mcont = 0;
    end else if (mt < 0) begin
      if (req0_a | req1_a) begin
        mwin = (req0_a & req1_a) ? ~mlast : req1_a;
        if (req0_a & req1_a && mcont < 255) mcont++;
        mlast = mwin;
        maddr = mwin ? addr1_a : addr0_a;
        mt = 1;
      end
    end else if (mt == LA + 1) begin
      if (mwin) md1 = romf(maddr);
      else      md0 = romf(maddr);
      mt++;
    end else if (mt == LA + 2) begin
      mt = -1;
    end else begin
      mt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_rom_en",   32'(rom_en_a),   32'(mt == 1));
      chk("m_rom_addr", 32'(rom_addr_a), 32'(maddr));
      chk("m_busy",     32'(busy_a),     32'(mt >= 1));
      chk("m_ack0",     32'(ack0_a),     32'(mt == LA + 2 && !mwin));
      chk("m_ack1",     32'(ack1_a),     32'(mt == LA + 2 && mwin));
      chk("m_data0",    32'(data0_a),    32'(md0));
      chk("m_data1",    32'(data1_a),    32'(md1));
      chk("m_contend",  32'(contend_a),  32'(mcont[7:0]));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    req0_a = 0; req1_a = 0; addr0_a = '0; addr1_a = '0;
    req0_b = 0; req1_b = 0; addr0_b = '0; addr1_b = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_rom_en", 32'(rom_en_a), 0);
    chk("rst_contend", 32'(contend_a), 0);
    chk("rst_data0", 32'(data0_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single port-0 access
    addr0_a = 11'h123; req0_a = 1;
    @(negedge clk);
    chk("t1_en_c1", 32'(rom_en_a), 1);
    chk("t1_addr_c1", 32'(rom_addr_a), 32'h123);
    @(negedge clk);
    chk("t1_en_c2", 32'(rom_en_a), 0);
    @(negedge clk);
    chk("t1_ack0_c3", 32'(ack0_a), 1);
    chk("t1_data0_c3", 32'(data0_a), 32'h0123);
    chk("t1_ack1_c3", 32'(ack1_a), 0);
    req0_a = 0;
    repeat (3) @(negedge clk);
    chk("t1_ack0_after", 32'(ack0_a), 0);

    // simultaneous requests after reset
    do_reset();
    addr0_a = 11'h010; addr1_a = 11'h020; req0_a = 1; req1_a = 1;
    repeat (3) @(negedge clk);
    chk("t2_ack0_c3", 32'(ack0_a), 1);
    chk("t2_data0_c3", 32'(data0_a), 32'h0010);
    chk("t2_ack1_c3", 32'(ack1_a), 0);
    req0_a = 0;
    repeat (4) @(negedge clk);
    chk("t2_ack1_c7", 32'(ack1_a), 1);
    chk("t2_data1_c7", 32'(data1_a), 32'h0020);
    chk("t2_contend", 32'(contend_a), 1);
    req1_a = 0;
    repeat (2) @(negedge clk);

    // eight back-to-back contended accesses
    do_reset();
    addr0_a = 11'h0A5; addr1_a = 11'h15A; req0_a = 1; req1_a = 1;
    for (int k = 0; k < 8; k++) begin
      repeat ((k == 0) ? 3 : 4) @(negedge clk);
      chk("t3_ack0", 32'(ack0_a), 32'((k % 2) == 0));
      chk("t3_ack1", 32'(ack1_a), 32'((k % 2) == 1));
    end
    req0_a = 0; req1_a = 0;
    @(negedge clk);
    chk("t3_contend", 32'(contend_a), 8);
    chk("t3_data0", 32'(data0_a), 32'h00A5);
    chk("t3_data1", 32'(data1_a), 32'h015A);

    // ROM_LAT=3 instance, port 1
    do_reset();
    addr1_b = 11'h7FF; req1_b = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t4_rom_en", 32'(rom_en_b), 32'(c == 1));
      chk("t4_ack1", 32'(ack1_b), 32'(c == 5));
      chk("t4_ack0", 32'(ack0_b), 0);
    end
    chk("t4_data1", 32'(data1_b), 32'h07FF);
    req1_b = 0;
    @(negedge clk);
    chk("t4_busy_after", 32'(busy_b), 0);

    // reset in the middle of WAIT
    do_reset();
    addr0_a = 11'h0AA; req0_a = 1;
    repeat (3) @(negedge clk);
    chk("t5_first_data0", 32'(data0_a), 32'h00AA);
    req0_a = 0;
    @(negedge clk);
    addr0_a = 11'h0BB; req0_a = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_a), 0);
    chk("t5_rom_en", 32'(rom_en_a), 0);
    chk("t5_ack0", 32'(ack0_a), 0);
    chk("t5_ack1", 32'(ack1_a), 0);
    chk("t5_data0", 32'(data0_a), 0);
    chk("t5_data1", 32'(data1_a), 0);
    chk("t5_contend", 32'(contend_a), 0);
    chk("t5_rom_addr", 32'(rom_addr_a), 0);
    req0_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_ack0", 32'(ack0_a), 0);
      chk("t5_no_ack1", 32'(ack1_a), 0);
    end
    addr1_a = 11'h055; req1_a = 1;
    repeat (3) @(negedge clk);
    chk("t5_ack1", 32'(ack1_a), 1);
    chk("t5_data1_after", 32'(data1_a), 32'h0055);
    req1_a = 0;
    repeat (2) @(negedge clk);

    // 300 contended grants: counter saturates
    do_reset();
    addr0_a = 11'h111; addr1_a = 11'h222; req0_a = 1; req1_a = 1;
    repeat (1200) @(negedge clk);
    chk("t6_contend_sat", 32'(contend_a), 255);
    chk("t6_data0", 32'(data0_a), 32'h0111);
    chk("t6_data1", 32'(data1_a), 32'h0222);
    req0_a = 0; req1_a = 0;
    repeat (3) @(negedge clk);
    chk("t6_contend_hold", 32'(contend_a), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maze_rom_arbiter.md
# maze_rom_arbiter

Shares the single read port of the maze ROM inside the frame generator between two requesters: the player controller (port 0) and a second maze walker, such as an enemy mover or path checker (port 1). Each requester sees a private req/ack read channel. The arbiter sequences one ROM access at a time through a small FSM and grants ties round-robin. It sits between the requesters and the frame generator's `rom_en`/`rom_addr`/`rom_data` pins and replaces the direct controller-to-ROM connection.

## Interface
- `AW`, default 11: ROM address width.
- `DW`, default 16: ROM data width.
- `ROM_LAT`, default 1: cycles from the `o_rom_en` cycle to the cycle `i_rom_data` is valid. Legal range 1..7.
- `clk`  in  1  system clock (25 MHz pixel clock domain).
- `rst`  in  1  asynchronous, active-low reset.
- `i_req0`  in  1  port 0 read request; held until `o_ack0`.
- `i_addr0`  in  AW  port 0 address; stable while `i_req0` is high.
- `o_ack0`  out  1  one-cycle pulse; `o_data0` is valid in that cycle.
- `o_data0`  out  DW  port 0 read data.
- `i_req1`, `i_addr1`, `o_ack1`, `o_data1`: same as port 0, for port 1.
- `o_rom_en`  out  1  ROM read enable.
- `o_rom_addr`  out  AW  ROM address.
- `i_rom_data`  in  DW  ROM read data.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_contend`  out  8  saturating count of grants made while both ports were requesting.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Samples `i_req0`/`i_req1`.
  - If exactly one request is high, that port wins.
  - If both are high, the port opposite `last` wins.
  - On a win: latch the winner id and that port's address into `addr_q`, set `last` = winner, go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE**
  - One cycle with `o_rom_en`=1.
  - Load the wait counter with `ROM_LAT`-1 and go to WAIT.
- **WAIT**
  - Lasts `ROM_LAT` cycles; the counter decrements each cycle.
  - In the last WAIT cycle (counter = 0), capture `i_rom_data` into the winner's `o_dataN` register, then go to RESP.
- **RESP**
  - One cycle with `o_ackN`=1 for the winner only.
  - Always returns to IDLE.
- `o_rom_addr` always drives `addr_q`. `o_rom_en` is high only in ISSUE.
- Requests are sampled only in IDLE.
  - A requester that deasserts `req` at the edge ending its ack cycle gets exactly one access.
  - A requester that keeps `req` high is re-arbitrated in the following IDLE.
- Changing an address after the grant has no effect on the access in flight.
- If `req` is dropped before its ack, the access still completes and the ack is still pulsed. Requesters ignore unsolicited acks.
- `o_dataNa` holds its value until the next ack on the same port. The other port's data register is never disturbed.
- `o_contend` increments by 1 on each IDLE grant where both requests were high, and saturates at 255.
- Reset (`rst`=0), asynchronous and at any time including mid-access:
  - State goes to IDLE.
  - `o_rom_en`, `o_ack0`, `o_ack1` and `o_busy` = 0.
  - `addr_q`, `o_data0`, `o_data1` and `o_contend` = 0.
  - `last` = 1, so port 0 wins the first tie.
  - An interrupted access never produces an ack.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Single access with `req` first high in IDLE cycle c0:
  - c1: ISSUE, `o_rom_en`=1.
  - c1+`ROM_LAT`: data captured (last WAIT cycle).
  - c2+`ROM_LAT`: RESP, ack high.
  - c3+`ROM_LAT`: IDLE.
- Latency from request to ack is `ROM_LAT`+2 cycles, so 3 cycles for `ROM_LAT`=1.
- Back-to-back throughput is one access per `ROM_LAT`+3 cycles (4 cycles for `ROM_LAT`=1).
- `o_busy` is high from c1 through the RESP cycle inclusive.

## Test plan
- Port 0 only, `ROM_LAT`=1, ROM model data = {5'b0, addr}. `i_addr0`=0x123 with `req` raised in c0 ->
  - `o_rom_en` high only in c1, with `o_rom_addr`=0x123.
  - `o_ack0`=1 in c3 with `o_data0`=0x0123.
  - `o_ack1` stays 0.
- Both ports request at the same time after reset, with addresses 0x010 and 0x020 ->
  - Port 0 is acked first with 0x0010, in c3.
  - Port 1 is acked with 0x0020 four cycles later.
  - `o_contend`=1 (only the first grant saw both requests).
- Both requests held high continuously for 8 accesses -> acks alternate 0,1,0,1,…, one every 4 cycles, and `o_contend`=8.
- `ROM_LAT`=3, port 1 requests addr 0x7FF -> ack1 in c5 with data 0x07FF; `o_rom_en` is high only in c1.
- `rst` pulsed low during WAIT -> all outputs 0 immediately. No ack follows. A subsequent port 1 request completes normally.
- Both ports held requesting for 300 grants -> `o_contend`=255 and stays there; the data still alternates correctly.
